// File: rtl/fpu_pkg.sv
// Shared encodings and helpers for the F-extension issue/sequencing stage.
package fpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OP_W = 3;
  localparam int unsigned RD_W = 5;

  localparam logic [OP_W-1:0] OP_FADD   = 3'b000;
  localparam logic [OP_W-1:0] OP_FSUB   = 3'b001;
  localparam logic [OP_W-1:0] OP_FMUL   = 3'b010;
  localparam logic [OP_W-1:0] OP_FSGNJ  = 3'b011;
  localparam logic [OP_W-1:0] OP_FSGNJN = 3'b100;
  localparam logic [OP_W-1:0] OP_FSGNJX = 3'b101;

  localparam logic [XLEN-1:0] CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_WB      = 2'd3
  } state_e;

  // Writeback payload presented to the integer pipeline.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            err;
  } wb_t;

  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_FADD) || (op == OP_FSUB) || (op == OP_FMUL);
  endfunction

endpackage

// File: rtl/fpu_sgnj.sv
// Combinational sign injection: mode 0 copies rs2 sign, 1 inverts it, 2 xors both signs.
module fpu_sgnj
  import fpu_pkg::*;
(
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [1:0]      mode,
  output logic [XLEN-1:0] res_c
);

  logic sign;

  always_comb begin
    sign = rs1[XLEN-1] ^ rs2[XLEN-1];
    case (mode)
      2'd0:    sign = rs2[XLEN-1];
      2'd1:    sign = ~rs2[XLEN-1];
      default: sign = rs1[XLEN-1] ^ rs2[XLEN-1];
    endcase
    res_c = {sign, rs1[XLEN-2:0]};
  end

endmodule

// File: rtl/fpu_op_sequencer.sv
// Issues one F-extension op at a time to the FP adder/multiplier FSMs and returns a tagged writeback.
module fpu_op_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OP_W-1:0] req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [RD_W-1:0] req_rd,
  output logic            add_start,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_result,
  input  logic            add_done,
  input  logic            add_busy,
  output logic            mul_start,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic [XLEN-1:0] mul_result,
  input  logic            mul_done,
  input  logic            mul_busy,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  cnt_q;
  wb_t               wb_q;
  logic [XLEN-1:0]   sgnj_res;
  logic              sel_mul, sel_done, sel_busy, timeout;
  logic [XLEN-1:0]   sel_result;

  fpu_sgnj u_sgnj (
    .rs1   (req_rs1),
    .rs2   (req_rs2),
    .mode  (2'(req_op - OP_FSGNJ)),
    .res_c (sgnj_res)
  );

  // Only the unit chosen by the latched op is observed; the other may do anything.
  assign sel_mul    = (op_q == OP_FMUL);
  assign sel_done   = sel_mul ? mul_done   : add_done;
  assign sel_busy   = sel_mul ? mul_busy   : add_busy;
  assign sel_result = sel_mul ? mul_result : add_result;
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  assign wb_rd   = wb_q.rd;
  assign wb_data = wb_q.data;
  assign wb_err  = wb_q.err;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (req_valid) state_d = is_arith(req_op) ? ST_WAIT : ST_WB;
      ST_WAIT:    if (sel_done || timeout) state_d = ST_RELEASE;
      ST_RELEASE: if (!sel_done && !sel_busy) state_d = ST_WB;
      ST_WB:      if (wb_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and operand/result latches, updated in step with state_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready <= 1'b1;
      op_q      <= '0;
      cnt_q     <= '0;
      add_start <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      wb_valid  <= 1'b0;
      wb_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          req_ready  <= 1'b0;
          op_q       <= req_op;
          cnt_q      <= '0;
          wb_q.rd    <= req_rd;
          wb_q.err   <= 1'b0;
          case (req_op)
            OP_FADD, OP_FSUB: begin
              add_start <= 1'b1;
              add_a     <= req_rs1;
              add_b     <= (req_op == OP_FSUB) ? {~req_rs2[XLEN-1], req_rs2[XLEN-2:0]} : req_rs2;
            end
            OP_FMUL: begin
              mul_start <= 1'b1;
              mul_a     <= req_rs1;
              mul_b     <= req_rs2;
            end
            OP_FSGNJ, OP_FSGNJN, OP_FSGNJX: begin
              wb_q.data <= sgnj_res;
              wb_valid  <= 1'b1;
            end
            default: begin
              wb_q.data <= CANON_NAN;
              wb_q.err  <= 1'b1;
              wb_valid  <= 1'b1;
            end
          endcase
        end
        ST_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (sel_done) begin
            add_start <= 1'b0;
            mul_start <= 1'b0;
            wb_q.data <= sel_result;
          end else if (timeout) begin
            add_start <= 1'b0;
            mul_start <= 1'b0;
            wb_q.data <= CANON_NAN;
            wb_q.err  <= 1'b1;
          end
        end
        ST_RELEASE: if (!sel_done && !sel_busy) wb_valid <= 1'b1;
        ST_WB: if (wb_ready) begin
          wb_valid  <= 1'b0;
          req_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Scoreboard bench for fpu_op_sequencer with behavioural adder/multiplier models.
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd;
  logic        add_start, mul_start;
  logic [31:0] add_a, add_b, mul_a, mul_b;
  logic        wb_valid, wb_ready, wb_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Unit models indexed 0 = adder, 1 = multiplier.
  logic        u_start [2];
  logic [31:0] u_a [2];
  logic [31:0] u_b [2];
  logic        u_done [2];
  logic        u_busy [2];
  logic [31:0] u_res [2];
  int          ph [2];
  int          cnt [2];
  int          lat [2];
  int          hold [2];
  bit          stub [2];
  bit          st_prev [2];
  int          rises [2];

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t sb_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign u_start[0] = add_start;
  assign u_start[1] = mul_start;
  assign u_a[0] = add_a;
  assign u_b[0] = add_b;
  assign u_a[1] = mul_a;
  assign u_b[1] = mul_b;

  fpu_op_sequencer #(.TIMEOUT_CYC(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .add_start  (add_start),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (u_res[0]),
    .add_done   (u_done[0]),
    .add_busy   (u_busy[0]),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (u_res[1]),
    .mul_done   (u_done[1]),
    .mul_busy   (u_busy[1]),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .wb_err     (wb_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Lookup of the few IEEE-754 results the directed vectors use.
  function automatic logic [31:0] fp_model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
    if (is_mul && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (!is_mul && a == 32'h3F80_0000 && b == 32'hBF80_0000) return 32'h0000_0000;
    if (!is_mul && a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
    return 32'hDEAD_BEEF;
  endfunction

  // Units: busy on start, done after lat cycles, done held while start high plus hold cycles.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        ph[u] <= 0; u_done[u] <= 1'b0; u_busy[u] <= 1'b0; u_res[u] <= '0;
      end else begin
        case (ph[u])
          0: if (u_start[u]) begin ph[u] <= 1; cnt[u] <= lat[u]; u_busy[u] <= 1'b1; end
          1: begin
            if (stub[u]) begin
              if (!u_start[u]) begin u_busy[u] <= 1'b0; ph[u] <= 0; end
            end else if (cnt[u] == 0) begin
              u_done[u] <= 1'b1; u_res[u] <= fp_model(u == 1, u_a[u], u_b[u]); ph[u] <= 2;
            end else cnt[u] <= cnt[u] - 1;
          end
          2: if (!u_start[u]) begin cnt[u] <= hold[u]; ph[u] <= 3; end
          default: begin
            if (cnt[u] == 0) begin u_done[u] <= 1'b0; u_busy[u] <= 1'b0; ph[u] <= 0; end
            else cnt[u] <= cnt[u] - 1;
          end
        endcase
      end
    end
  end

  // Monitor: writeback compare on handshake, plus clean-restart check on every start rise.
  always @(negedge clk) begin
    if (!rst && wb_valid && wb_ready) begin
      if (sb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
        chk("wb_data", wb_data, e.data);
        chk("wb_err", 32'(wb_err), 32'(e.err));
      end
    end
    for (int u = 0; u < 2; u++) begin
      if (!rst && u_start[u] && !st_prev[u]) begin
        rises[u]++;
        chk(u == 0 ? "add_restart_clean" : "mul_restart_clean", 32'({u_done[u], u_busy[u]}), 32'd0);
      end
      st_prev[u] = u_start[u];
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] ed, input logic ee);
    int n = 0;
    while (!req_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("issue_ready_timeout", 32'd0, 32'd1);
    req_op = op; req_rs1 = a; req_rs2 = b; req_rd = rd; req_valid = 1'b1;
    sb_q.push_back('{rd: rd, data: ed, err: ee});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(req_ready && sb_q.size() == 0) && n < 400) begin @(posedge clk); #1; n++; end
    chk(name, 32'(req_ready && sb_q.size() == 0), 32'd1);
  endtask

  int r0, r1, n;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    wb_ready = 1'b1;
    for (int u = 0; u < 2; u++) begin
      lat[u] = 2; hold[u] = 0; stub[u] = 1'b0; st_prev[u] = 1'b0; rises[u] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_outputs", 32'({wb_valid, add_start, mul_start, wb_err}), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // FMUL 2.0 * 3.0
    r0 = rises[0];
    issue(3'b010, 32'h4000_0000, 32'h4040_0000, 5'd5, 32'h40C0_0000, 1'b0);
    chk("fmul_start", 32'(mul_start), 32'd1);
    chk("fmul_ops", {mul_a[15:0], mul_b[31:16]}, 32'h0000_4040);
    chk("fmul_a", mul_a, 32'h4000_0000);
    wait_idle("fmul_done");
    chk("fmul_no_add_start", 32'(rises[0] - r0), 32'd0);

    // FSUB 1.0 - 1.0
    issue(3'b001, 32'h3F80_0000, 32'h3F80_0000, 5'd6, 32'h0000_0000, 1'b0);
    chk("fsub_start", 32'(add_start), 32'd1);
    chk("fsub_add_b", add_b, 32'hBF80_0000);
    wait_idle("fsub_done");

    // Sign injection completes one cycle after accept, with no unit start
    r0 = rises[0]; r1 = rises[1];
    issue(3'b100, 32'h3F80_0000, 32'h3F80_0000, 5'd7, 32'hBF80_0000, 1'b0);
    chk("fsgnjn_latency", 32'(wb_valid), 32'd1);
    wait_idle("fsgnjn_done");
    issue(3'b101, 32'hBF80_0000, 32'hBF80_0000, 5'd8, 32'h3F80_0000, 1'b0);
    chk("fsgnjx_latency", 32'(wb_valid), 32'd1);
    wait_idle("fsgnjx_done");
    chk("sgnj_no_start", 32'((rises[0] - r0) + (rises[1] - r1)), 32'd0);

    // Timeout with a multiplier that never finishes
    stub[1] = 1'b1;
    issue(3'b010, 32'h4000_0000, 32'h4040_0000, 5'd9, 32'h7FC0_0000, 1'b1);
    n = 0;
    while (mul_start && n < 200) begin n++; @(posedge clk); #1; end
    chk("timeout_cycles", 32'(n), 32'd64);
    wait_idle("timeout_done");
    stub[1] = 1'b0;

    // Illegal op
    issue(3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd10, 32'h7FC0_0000, 1'b1);
    chk("illegal_latency", 32'(wb_valid), 32'd1);
    chk("illegal_err", 32'(wb_err), 32'd1);
    wait_idle("illegal_done");

    // Writeback back-pressure holds outputs stable
    wb_ready = 1'b0;
    issue(3'b011, 32'h3F80_0000, 32'hBF80_0000, 5'd12, 32'hBF80_0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_wb_valid", 32'(wb_valid), 32'd1);
      chk("bp_wb_data", wb_data, 32'hBF80_0000);
      chk("bp_wb_rd", 32'(wb_rd), 32'd12);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    wait_idle("bp_done");

    // Back-to-back FMULs with done held after start drops
    hold[1] = 3;
    r1 = rises[1];
    issue(3'b010, 32'h4000_0000, 32'h4040_0000, 5'd1, 32'h40C0_0000, 1'b0);
    issue(3'b010, 32'h4000_0000, 32'h4040_0000, 5'd2, 32'h40C0_0000, 1'b0);
    wait_idle("b2b_done");
    chk("b2b_mul_starts", 32'(rises[1] - r1), 32'd2);
    hold[1] = 0;

    // Reset during WAIT
    stub[1] = 1'b1;
    issue(3'b010, 32'h4000_0000, 32'h4040_0000, 5'd3, 32'h40C0_0000, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk); #1;
    chk("midrst_mul_start", 32'(mul_start), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;
    stub[1] = 1'b0;
    @(posedge clk); #1;
    issue(3'b000, 32'h3F80_0000, 32'h3F80_0000, 5'd4, 32'h4000_0000, 1'b0);
    wait_idle("post_rst_fadd_done");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
